// File: rtl/e203_itcm_fetch_pkg.sv
// Shared types and sizing helpers for the ITCM fetch initiator.
package e203_itcm_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int ICB_DW     = 64;
    localparam int BEAT_BYTES = ICB_DW / 8;

    // Bytes advanced per ICB beat for a given data width.
    function automatic int beat_bytes(input int dw);
        return dw / 8;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width able to index n entries (at least one bit).
    function automatic int ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/e203_itcm_fetch_rbuf.sv
// Response buffer: small first-word-fall-through FIFO with flush and occupancy count.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module e203_itcm_fetch_rbuf
    import e203_itcm_fetch_pkg::*;
#(
    parameter int W     = 66,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      push,
    input  logic [W-1:0]              push_data,
    input  logic                      pop,
    output logic [W-1:0]              pop_data,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && ((count_reg != DEPTH_C) || pop_ok);
    assign pop_data = mem[rd_ptr_reg];

    // Storage array: written on accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/e203_itcm_fetch_initiator.sv
// ICB read initiator: turns one burst request into sequential beat reads,
// limits outstanding commands by free buffer space and streams the responses out.
module e203_itcm_fetch_initiator
    import e203_itcm_fetch_pkg::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 64,
    parameter int LEN_W = 8,
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [AW-1:0]     req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic              busy,
    output logic              icb_cmd_valid,
    input  logic              icb_cmd_ready,
    output logic [AW-1:0]     icb_cmd_addr,
    output logic              icb_cmd_read,
    output logic [DW-1:0]     icb_cmd_wdata,
    output logic [DW/8-1:0]   icb_cmd_wmask,
    input  logic              icb_rsp_valid,
    output logic              icb_rsp_ready,
    input  logic [DW-1:0]     icb_rsp_rdata,
    input  logic              icb_rsp_err,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DW-1:0]     dout_data,
    output logic              dout_err,
    output logic              dout_last
);

    localparam int BB  = beat_bytes(DW);
    localparam int OFF = $clog2(BB);
    localparam int CW  = cnt_w(DEPTH);
    localparam int LW1 = LEN_W + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    fetch_state_e      state_reg;
    fetch_state_e      state_next;
    logic [AW-1:0]     addr_reg;
    logic [LEN_W:0]    cmd_left_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic [CW-1:0]     outst_reg;
    logic              discard_reg;

    logic [CW-1:0]     buf_count;
    logic              buf_empty;
    logic [DW+1:0]     buf_head;
    logic              req_fire;
    logic              cmd_fire;
    logic              rsp_take;
    logic              push;
    logic              pop;
    logic              abort_hit;
    logic              err_hit;
    logic              beat_last;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[OFF-1:0];

    assign req_ready     = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign req_fire      = req_valid && req_ready;
    // Credit check: every outstanding command must have a guaranteed buffer slot.
    assign icb_cmd_valid = (state_reg == ISSUE) &&
                           (({1'b0, outst_reg} + {1'b0, buf_count}) < DEPTH_C);
    assign cmd_fire      = icb_cmd_valid && icb_cmd_ready;
    assign icb_cmd_addr  = addr_reg;
    assign icb_cmd_read  = 1'b1;
    assign icb_cmd_wdata = '0;
    assign icb_cmd_wmask = '0;
    assign icb_rsp_ready = 1'b1;

    // Responses with nothing outstanding (e.g. stragglers after reset) are dropped silently.
    assign rsp_take  = icb_rsp_valid && (outst_reg != '0);
    assign abort_hit = abort && busy;
    assign push      = rsp_take && !discard_reg && !abort_hit && busy;
    assign err_hit   = push && icb_rsp_err;
    assign beat_last = icb_rsp_err || (beat_reg == len_reg);
    assign pop       = dout_valid && dout_ready;

    assign dout_valid = !buf_empty;
    assign dout_data  = buf_head[DW-1:0];
    assign dout_last  = dout_valid && buf_head[DW];
    assign dout_err   = dout_valid && buf_head[DW+1];

    e203_itcm_fetch_rbuf #(
        .W     (DW + 2),
        .DEPTH (DEPTH)
    ) u_rbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (abort_hit),
        .push      (push),
        .push_data ({icb_rsp_err, beat_last, icb_rsp_rdata}),
        .pop       (pop),
        .pop_data  (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Next-state: stop issuing on the last command, abort or error; leave DRAIN once quiet.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_fire) state_next = ISSUE;
            end
            ISSUE: begin
                if (abort_hit || err_hit || (cmd_fire && cmd_left_reg == LW1'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((outst_reg == '0) && buf_empty) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, address/beat/outstanding counters and the discard flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            cmd_left_reg <= '0;
            len_reg      <= '0;
            beat_reg     <= '0;
            outst_reg    <= '0;
            discard_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            outst_reg <= outst_reg + CW'(cmd_fire) - CW'(rsp_take);
            if (req_fire) begin
                addr_reg     <= {req_addr[AW-1:OFF], {OFF{1'b0}}};
                len_reg      <= req_len;
                cmd_left_reg <= {1'b0, req_len} + LW1'(1);
                beat_reg     <= '0;
                discard_reg  <= 1'b0;
            end else begin
                if (cmd_fire) begin
                    addr_reg     <= addr_reg + AW'(BB);
                    cmd_left_reg <= cmd_left_reg - LW1'(1);
                end
                if (push) begin
                    beat_reg <= beat_reg + LEN_W'(1);
                end
                if (abort_hit || err_hit) begin
                    discard_reg <= 1'b1;
                end
            end
        end
    end

endmodule
